id_ex_elastic_reg: RTL and testbench
====================================

// Module: id_ex_elastic_reg
// PURPOSE
// - Parametrised ID->EX pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// - Successor to the plain ID/EX latch: adds backpressure (EX may stall), bubble tracking and squash on branch/jump.
// - Sits between the decoder (ID) and ALU (EX); payload is aluop, alusel, two operands, pc, write-back enable/addr.
// PARAMETERS
// - XLEN        32  operand / pc width
// - ALUOP_W     8   width of aluop field
// - ALUSEL_W    3   width of alusel field
// - REGADDR_W   5   register-file address width
// - NOP_ALUOP   0   aluop value driven when slot invalid
// - NOP_ALUSEL  0   alusel value driven when slot invalid
// - CNT_W       32  stall counter width (only with ID_EX_STALL_CNT_EN)
// PORTS
// - clk          in   1          clock, all state on rising edge
// - rst          in   1          synchronous reset, active-high
// - flush        in   1          squash all held and incoming entries
// - id_valid     in   1          ID presents a valid instruction
// - id_ready     out  1          register can accept this cycle
// - id_aluop     in   ALUOP_W    decoded ALU op
// - id_alusel    in   ALUSEL_W   result select
// - id_r1_data   in   XLEN       operand 1
// - id_r2_data   in   XLEN       operand 2
// - id_pc        in   XLEN       instruction pc
// - id_w_enable  in   1          write-back enable
// - id_w_addr    in   REGADDR_W  write-back register
// - ex_valid     out  1          EX slot holds valid instruction
// - ex_ready     in   1          EX consumes slot this cycle
// - ex_aluop/ex_alusel/ex_r1_data/ex_r2_data/ex_pc/ex_w_enable/ex_w_addr  out  (as id_*)  registered payload
// - stall_cnt    out  CNT_W      EX stall cycles (only with ID_EX_STALL_CNT_EN)
// BEHAVIOUR
// - Accept = id_valid & id_ready; consume = ex_valid & ex_ready. Latency 1 cycle ID->EX when not stalled.
// - id_ready = !skid_valid & !rst (registered-state derived; no comb path from ex_ready to id_ready).
// - Storage: main slot (drives ex_*) + skid slot. States: EMPTY (main 0, skid 0), ONE (1,0), TWO (1,1).
// - EMPTY: accept -> ONE (main<=in). Else stay.
// - ONE: accept&consume -> ONE (main<=in); accept&!consume -> TWO (skid<=in); !accept&consume -> EMPTY.
// - TWO: id_ready=0; consume -> ONE (main<=skid); else hold.
// - ex_valid = main valid. Order strictly preserved; no entry dropped or duplicated except by flush/rst.
// - When main invalid, ex_* forced to NOP: aluop=NOP_ALUOP, alusel=NOP_ALUSEL, r1/r2/pc=0, w_enable=0, w_addr=0.
// - ex_w_enable is never 1 while ex_valid=0.
// - flush (below rst, above all else): next cycle EMPTY; same-cycle accept and consume are discarded.
// - rst: next cycle EMPTY, all ex_* at NOP values, ex_valid=0, stall_cnt=0; id_ready=0 while rst high.
// - Reset/flush mid-stall (TWO) drops both entries; no partial update of payload fields.
// CONFIGURATION
// - ID_EX_STALL_CNT_EN defined: stall_cnt port present; increments when ex_valid & !ex_ready & !flush;
//   saturates at 2^CNT_W-1; cleared only by rst.
// - Not defined: port and counter absent; all other behaviour identical.
// TESTING
// - Stream 5 instrs, ex_ready=1 -> each appears on ex_* exactly 1 cycle after accept, ex_valid continuous.
// - Accept A, hold ex_ready=0, offer B,C -> B taken (TWO), id_ready=0, C held; ex_ready=1 -> A,B,C in order.
// - In TWO assert flush -> next cycle ex_valid=0, ex_aluop=NOP_ALUOP, ex_w_enable=0, id_ready=1.
// - Flush with id_valid=1 in EMPTY -> input discarded, ex_valid stays 0.
// - rst during stream -> next cycle all ex_* NOP, ex_valid=0; id_ready=0 while rst=1.
// - STALL_CNT_EN, CNT_W=4: 20 stall cycles -> stall_cnt=15 (saturated); rst -> 0.

Source files
------------

// File: rtl/id_ex_elastic_reg.sv
// id_ex_elastic_reg
// Elastic ID->EX pipeline register. A main slot drives the EX side and a
// skid slot absorbs one extra instruction when EX stalls. This lets the
// ready signal back to ID be a function of registered state only.
// Flush squashes everything that is held or arriving in the same cycle.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   i_flush                   squash held and incoming entries
//   i_id_valid / o_id_ready   ID-side handshake
//   i_id_*                    decoded payload from ID
//   o_ex_valid / i_ex_ready   EX-side handshake
//   o_ex_*                    registered payload (NOP values when invalid)
//   o_stall_cnt               saturating EX stall counter (ID_EX_STALL_CNT_EN only)
//
// Build option: define ID_EX_STALL_CNT_EN to add the stall counter and its port.
module id_ex_elastic_reg #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALUOP_W    = 8,
    parameter int unsigned ALUSEL_W   = 3,
    parameter int unsigned REGADDR_W  = 5,
    parameter int unsigned NOP_ALUOP  = 0,
    parameter int unsigned NOP_ALUSEL = 0,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_id_valid,
    output logic                 o_id_ready,
    input  logic [ALUOP_W-1:0]   i_id_aluop,
    input  logic [ALUSEL_W-1:0]  i_id_alusel,
    input  logic [XLEN-1:0]      i_id_r1_data,
    input  logic [XLEN-1:0]      i_id_r2_data,
    input  logic [XLEN-1:0]      i_id_pc,
    input  logic                 i_id_w_enable,
    input  logic [REGADDR_W-1:0] i_id_w_addr,
    output logic                 o_ex_valid,
    output logic [ALUOP_W-1:0]   o_ex_aluop,
    output logic [ALUSEL_W-1:0]  o_ex_alusel,
    output logic [XLEN-1:0]      o_ex_r1_data,
    output logic [XLEN-1:0]      o_ex_r2_data,
    output logic [XLEN-1:0]      o_ex_pc,
    output logic                 o_ex_w_enable,
    output logic [REGADDR_W-1:0] o_ex_w_addr,
`ifdef ID_EX_STALL_CNT_EN
    output logic [CNT_W-1:0]     o_stall_cnt,
`endif
    input  logic                 i_ex_ready
);

    typedef struct packed {
        logic [ALUOP_W-1:0]   aluop;
        logic [ALUSEL_W-1:0]  alusel;
        logic [XLEN-1:0]      r1_data;
        logic [XLEN-1:0]      r2_data;
        logic [XLEN-1:0]      pc;
        logic                 w_enable;
        logic [REGADDR_W-1:0] w_addr;
    } payload_t;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    payload_t   r_main;
    payload_t   r_skid;
    payload_t   w_main_nxt;
    payload_t   w_skid_nxt;
    payload_t   w_nop;
    payload_t   w_in;
    logic       w_main_valid;
    logic       w_accept;
    logic       w_consume;

    // NOP payload and incoming payload bundles
    always_comb begin
        w_nop        = '0;
        w_nop.aluop  = ALUOP_W'(NOP_ALUOP);
        w_nop.alusel = ALUSEL_W'(NOP_ALUSEL);
        w_in         = '{aluop:    i_id_aluop,
                         alusel:   i_id_alusel,
                         r1_data:  i_id_r1_data,
                         r2_data:  i_id_r2_data,
                         pc:       i_id_pc,
                         w_enable: i_id_w_enable,
                         w_addr:   i_id_w_addr};
    end

    assign w_main_valid = (r_state == S_ONE) || (r_state == S_TWO);
    // Ready depends only on state and reset, never on i_ex_ready
    assign o_id_ready   = (r_state != S_TWO) && !rst;
    assign w_accept     = i_id_valid && o_id_ready;
    assign w_consume    = w_main_valid && i_ex_ready;

    // State register; main slot is reloaded with NOP whenever it empties
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= w_nop;
            r_skid  <= w_nop;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Next-state and slot update
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (i_flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = w_nop;
            w_skid_nxt  = w_nop;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = w_in;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_nxt  = w_in;
                    end else if (w_accept) begin
                        w_state_nxt = S_TWO;
                        w_skid_nxt  = w_in;
                    end else if (w_consume) begin
                        w_state_nxt = S_EMPTY;
                        w_main_nxt  = w_nop;
                    end
                end
                S_TWO: begin
                    if (w_consume) begin
                        w_state_nxt = S_ONE;
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = w_nop;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = w_nop;
                    w_skid_nxt  = w_nop;
                end
            endcase
        end
    end

    assign o_ex_valid    = w_main_valid;
    assign o_ex_aluop    = r_main.aluop;
    assign o_ex_alusel   = r_main.alusel;
    assign o_ex_r1_data  = r_main.r1_data;
    assign o_ex_r2_data  = r_main.r2_data;
    assign o_ex_pc       = r_main.pc;
    assign o_ex_w_enable = r_main.w_enable;
    assign o_ex_w_addr   = r_main.w_addr;

`ifdef ID_EX_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles EX holds a valid instruction without taking it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !i_ex_ready && !i_flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Scoreboard bench for id_ex_elastic_reg: the driver pushes each accepted
// instruction, a negedge monitor compares EX-side output against the queue.
module tb_id_ex_elastic_reg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ALUOP_W   = 8;
    localparam int unsigned ALUSEL_W  = 3;
    localparam int unsigned REGADDR_W = 5;
    localparam int unsigned NOP_AOP   = 165;  // 8'hA5
    localparam int unsigned NOP_ASEL  = 5;
    localparam int unsigned CNT_W     = 4;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] r1_data;
        logic [31:0] r2_data;
        logic [31:0] pc;
        logic        w_enable;
        logic [4:0]  w_addr;
    } pl_t;

    typedef struct {
        pl_t p;
        int  t_acc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic i_flush;
    logic i_id_valid;
    logic o_id_ready;
    logic [7:0]  i_id_aluop;
    logic [2:0]  i_id_alusel;
    logic [31:0] i_id_r1_data;
    logic [31:0] i_id_r2_data;
    logic [31:0] i_id_pc;
    logic        i_id_w_enable;
    logic [4:0]  i_id_w_addr;
    logic        o_ex_valid;
    logic [7:0]  o_ex_aluop;
    logic [2:0]  o_ex_alusel;
    logic [31:0] o_ex_r1_data;
    logic [31:0] o_ex_r2_data;
    logic [31:0] o_ex_pc;
    logic        o_ex_w_enable;
    logic [4:0]  o_ex_w_addr;
    logic        i_ex_ready;
`ifdef ID_EX_STALL_CNT_EN
    logic [CNT_W-1:0] o_stall_cnt;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   chk_lat = 0;
    bit   front_seen = 0;
    ent_t q[$];
    pl_t  w_ex_pl;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    id_ex_elastic_reg #(
        .XLEN(XLEN), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W), .REGADDR_W(REGADDR_W),
        .NOP_ALUOP(NOP_AOP), .NOP_ALUSEL(NOP_ASEL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush),
        .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
        .i_id_aluop(i_id_aluop), .i_id_alusel(i_id_alusel),
        .i_id_r1_data(i_id_r1_data), .i_id_r2_data(i_id_r2_data),
        .i_id_pc(i_id_pc), .i_id_w_enable(i_id_w_enable), .i_id_w_addr(i_id_w_addr),
        .o_ex_valid(o_ex_valid),
        .o_ex_aluop(o_ex_aluop), .o_ex_alusel(o_ex_alusel),
        .o_ex_r1_data(o_ex_r1_data), .o_ex_r2_data(o_ex_r2_data),
        .o_ex_pc(o_ex_pc), .o_ex_w_enable(o_ex_w_enable), .o_ex_w_addr(o_ex_w_addr),
`ifdef ID_EX_STALL_CNT_EN
        .o_stall_cnt(o_stall_cnt),
`endif
        .i_ex_ready(i_ex_ready)
    );

    assign w_ex_pl = {o_ex_aluop, o_ex_alusel, o_ex_r1_data, o_ex_r2_data,
                      o_ex_pc, o_ex_w_enable, o_ex_w_addr};

    function automatic pl_t nop_pl();
        pl_t p = '0;
        p.aluop  = 8'hA5;
        p.alusel = 3'd5;
        return p;
    endfunction

    function automatic pl_t mk(input int k);
        pl_t p;
        p.aluop    = 8'(k * 3 + 1);
        p.alusel   = 3'(k);
        p.r1_data  = 32'h1000_0000 + 32'(k);
        p.r2_data  = ~32'(k);
        p.pc       = 32'h0000_0400 + 32'(k * 4);
        p.w_enable = k[0];
        p.w_addr   = 5'(k + 1);
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_pl(input pl_t p);
        i_id_aluop    = p.aluop;
        i_id_alusel   = p.alusel;
        i_id_r1_data  = p.r1_data;
        i_id_r2_data  = p.r2_data;
        i_id_pc       = p.pc;
        i_id_w_enable = p.w_enable;
        i_id_w_addr   = p.w_addr;
    endtask

    // Offer one instruction until accepted; expected entry pushed on acceptance
    task automatic send(input pl_t p);
        bit done = 0;
        drive_pl(p);
        i_id_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (o_id_ready && !i_flush && !rst) begin
                q.push_back('{p: p, t_acc: cyc});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 128'd0, 128'd1);
        i_id_valid = 1'b0;
    endtask

    // Monitor: compare EX output against scoreboard head, pop on consume
    always @(negedge clk) begin
        if (rst || i_flush) begin
            q.delete();
            front_seen = 0;
        end else if (o_ex_valid) begin
            if (q.size() == 0) begin
                check("ex_valid_unexpected", 128'(o_ex_valid), 128'd0);
            end else begin
                check("ex_payload", 128'(w_ex_pl), 128'(q[0].p));
                if (!front_seen && chk_lat)
                    check("latency", 128'(cyc), 128'(q[0].t_acc + 1));
                front_seen = 1;
                if (i_ex_ready) begin
                    void'(q.pop_front());
                    front_seen = 0;
                end
            end
        end else begin
            check("idle_nop", 128'(w_ex_pl), 128'(nop_pl()));
        end
    end

    initial begin
        rst = 1'b1; i_flush = 1'b0; i_id_valid = 1'b0; i_ex_ready = 1'b0;
        drive_pl(mk(99));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_id_ready", 128'(o_id_ready), 128'd0);
        check("rst_ex_valid", 128'(o_ex_valid), 128'd0);
        check("rst_payload", 128'(w_ex_pl), 128'(nop_pl()));
`ifdef ID_EX_STALL_CNT_EN
        check("rst_stall_cnt", 128'(o_stall_cnt), 128'd0);
`endif
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_id_ready", 128'(o_id_ready), 128'd1);
        @(posedge clk); #1;

        // Streaming with EX always ready: one-cycle latency, back to back
        i_ex_ready = 1'b1;
        chk_lat = 1;
        for (int k = 0; k < 5; k++) send(mk(k));
        chk_lat = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stream_drained", 128'(q.size()), 128'd0);
        @(posedge clk); #1;

        // Stall: A in main, B in skid, C held off until EX drains
        i_ex_ready = 1'b0;
        send(mk(10));
        send(mk(11));
        drive_pl(mk(12));
        i_id_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("two_id_ready", 128'(o_id_ready), 128'd0);
            check("two_hold_a", 128'(w_ex_pl), 128'(mk(10)));
        end
        @(posedge clk); #1 i_ex_ready = 1'b1;
        send(mk(12));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_drained", 128'(q.size()), 128'd0);
        @(posedge clk); #1;

        // Flush while full
        i_ex_ready = 1'b0;
        send(mk(20));
        send(mk(21));
        @(negedge clk);
        check("flush_pre_two", 128'(o_id_ready), 128'd0);
        @(posedge clk); #1 i_flush = 1'b1;
        @(posedge clk); #1 i_flush = 1'b0;
        @(negedge clk);
        check("flush_ex_valid", 128'(o_ex_valid), 128'd0);
        check("flush_aluop", 128'(o_ex_aluop), 128'hA5);
        check("flush_w_enable", 128'(o_ex_w_enable), 128'd0);
        check("flush_id_ready", 128'(o_id_ready), 128'd1);
        @(posedge clk); #1;

        // Flush in EMPTY with a valid input: input discarded
        i_ex_ready = 1'b1;
        drive_pl(mk(30));
        i_id_valid = 1'b1;
        i_flush = 1'b1;
        @(posedge clk); #1 i_id_valid = 1'b0; i_flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("flush_empty_ex_valid", 128'(o_ex_valid), 128'd0);
        end
        @(posedge clk); #1;

        // Reset in the middle of a stream
        send(mk(40));
        send(mk(41));
        drive_pl(mk(42));
        i_id_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_id_ready", 128'(o_id_ready), 128'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_ex_valid", 128'(o_ex_valid), 128'd0);
        check("rst_mid_payload", 128'(w_ex_pl), 128'(nop_pl()));
        @(posedge clk); #1 rst = 1'b0; i_id_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_after", 128'(o_ex_valid), 128'd0);
        check("rst_mid_ready_after", 128'(o_id_ready), 128'd1);
        @(posedge clk); #1;

`ifdef ID_EX_STALL_CNT_EN
        // Stall counter counts, saturates at 15, clears on reset
        @(negedge clk);
        check("cnt_zero", 128'(o_stall_cnt), 128'd0);
        @(posedge clk); #1;
        i_ex_ready = 1'b0;
        send(mk(50));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("cnt_three", 128'(o_stall_cnt), 128'd3);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("cnt_saturated", 128'(o_stall_cnt), 128'd15);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("cnt_cleared", 128'(o_stall_cnt), 128'd0);
        @(posedge clk); #1;
`endif

        i_ex_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("final_drained", 128'(q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
